cyber_player: RTL
=================

// Module: cyber_player
// PURPOSE
//   Computer opponent for the tug-of-war game; sits directly downstream of the 9-bit LFSR.
//   Samples the LFSR value on a paced decision tick and compares it against a switch-set threshold.
//   Emits a one-cycle "press" pulse to the playfield logic, followed by a mandatory cooldown.
//   Higher threshold = stronger opponent.
// PARAMETERS
//   WIDTH     9   width of rand_val and threshold
//   TICK_DIV  16  clock cycles per decision tick (>=2)
//   COOLDOWN  4   idle cycles forced after each press (0 allowed)
// PORTS
//   clk          in   1      system clock, all state updates on posedge
//   reset        in   1      synchronous, active-high
//   rand_val     in   WIDTH  current LFSR output, sampled only on a decision tick
//   threshold    in   WIDTH  difficulty setting from switches, unsigned
//   enable       in   1      1 = computer player active
//   game_over    in   1      1 = round finished, suppress all presses
//   press        out  1      registered one-cycle press pulse
//   press_count  out  8      presses since reset; present only with CYBER_PRESS_CNT_EN
// BEHAVIOUR
//   Reset (sync, active-high): state=IDLE, tick_cnt=0, cd_cnt=0, press=0, press_count=0.
//   Tick counter:
//     - free-runs 0..TICK_DIV-1 and wraps to 0.
//     - tick=1 when tick_cnt==TICK_DIV-1.
//     - runs in every state; not cleared by enable or game_over.
//   States:
//     IDLE: on tick & enable & !game_over & (rand_val < threshold) -> PRESS; otherwise stay.
//     PRESS: press=1 for exactly this cycle.
//       - COOLDOWN>0 -> COOLDOWN state, load cd_cnt=COOLDOWN-1.
//       - COOLDOWN==0 -> IDLE.
//     COOLDOWN: cd_cnt decrements each cycle; at cd_cnt==0 -> IDLE. Ticks here are ignored.
//   Latency: press rises the cycle after the qualifying tick edge (1-cycle registered).
//   Compare: strict unsigned less-than at full WIDTH.
//     - threshold=0 never presses.
//     - threshold=2^WIDTH-1 presses on every eligible tick except rand_val==2^WIDTH-1.
//   Priority: game_over has top priority.
//     - Asserting it in any state sends the FSM to IDLE next cycle.
//     - A press already registered completes its single cycle; no new press while game_over=1.
//   enable deasserted: no new decisions; PRESS/COOLDOWN in flight still complete normally.
//   Simultaneous tick and COOLDOWN->IDLE transition: the tick is ignored; the next decision is at the following tick.
//   Reset mid-press or mid-cooldown: press=0 next cycle, all counters cleared.
//   press is never high two consecutive cycles; minimum spacing is max(TICK_DIV, COOLDOWN+1) cycles.
// CONFIGURATION
//   CYBER_PRESS_CNT_EN defined:
//     - adds output press_count[7:0]; increments on every cycle press=1.
//     - saturates at 255; cleared only by reset.
//   CYBER_PRESS_CNT_EN undefined:
//     - press_count port and its counter are absent.
//     - all other behaviour is identical.
// TESTING (WIDTH=9, TICK_DIV=4, COOLDOWN=2 unless stated)
//   1. Reset held 3 cycles, then released with rand_val=5, threshold=10, enable=1
//      -> press=0 during reset; first press on the cycle after tick_cnt==3.
//   2. threshold=0, enable=1, 512 cycles of sweeping rand_val -> press never asserts.
//   3. rand_val=0, threshold=511 held constant
//      -> press pulses every 4 cycles, each exactly 1 cycle wide.
//   4. COOLDOWN=6, TICK_DIV=4, always-true compare
//      -> presses spaced 8 cycles apart (tick during cooldown skipped).
//   5. game_over=1 asserted in the PRESS cycle
//      -> press drops next cycle; no press while game_over=1.
//      -> after game_over=0, presses resume at the next tick.
//   6. CYBER_PRESS_CNT_EN defined, 300 forced presses
//      -> press_count reads 255 and holds; reset returns it to 0.

Source files
------------

// File: rtl/cyber_player.sv
// cyber_player: computer opponent for the tug-of-war game.
// On each paced decision tick it compares the LFSR value against a switch-set threshold.
// When the LFSR value is below the threshold it issues a one-cycle press pulse, then
// holds off for a fixed cooldown. A higher threshold makes a stronger opponent.
// Optional feature macro: CYBER_PRESS_CNT_EN adds a saturating 8-bit press counter.
module cyber_player #(
    parameter int unsigned WIDTH    = 9,
    parameter int unsigned TICK_DIV = 16,
    parameter int unsigned COOLDOWN = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] rand_val,
    input  logic [WIDTH-1:0] threshold,
    input  logic             enable,
    input  logic             game_over,
    output logic             press
`ifdef CYBER_PRESS_CNT_EN
    ,
    output logic [7:0]       press_count
`endif
);

    localparam int unsigned TICK_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned CD_W   = (COOLDOWN > 2) ? $clog2(COOLDOWN) : 1;
    localparam int unsigned CD_INIT = (COOLDOWN == 0) ? 0 : COOLDOWN - 1;

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
    localparam logic [CD_W-1:0]   CD_LOAD   = CD_W'(CD_INIT);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRESS = 2'd1,
        ST_COOL  = 2'd2
    } state_t;

    state_t            state;
    logic [TICK_W-1:0] tick_cnt;
    logic [CD_W-1:0]   cd_cnt;
    logic              tick_c;
    logic              decide_c;

    assign tick_c   = (tick_cnt == TICK_LAST);
    assign decide_c = tick_c && enable && !game_over && (rand_val < threshold);

    // Free-running decision pacer; independent of enable, game_over and FSM state.
    always_ff @(posedge clk) begin
        if (reset) begin
            tick_cnt <= '0;
        end else if (tick_c) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + TICK_W'(1);
        end
    end

    // Decision FSM; game_over overrides everything and forces a return to IDLE.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= ST_IDLE;
            cd_cnt <= '0;
            press  <= 1'b0;
        end else if (game_over) begin
            state  <= ST_IDLE;
            cd_cnt <= '0;
            press  <= 1'b0;
        end else begin
            press <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (decide_c) begin
                        state <= ST_PRESS;
                        press <= 1'b1;
                    end
                end
                ST_PRESS: begin
                    if (COOLDOWN != 0) begin
                        state  <= ST_COOL;
                        cd_cnt <= CD_LOAD;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_COOL: begin
                    // Ticks landing here, including on the exit cycle, are dropped.
                    if (cd_cnt == '0) begin
                        state <= ST_IDLE;
                    end else begin
                        cd_cnt <= cd_cnt - CD_W'(1);
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    cd_cnt <= '0;
                end
            endcase
        end
    end

`ifdef CYBER_PRESS_CNT_EN
    // Saturating count of issued presses, cleared only by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            press_count <= '0;
        end else if (press && (press_count != 8'hFF)) begin
            press_count <= press_count + 8'd1;
        end
    end
`endif

endmodule
